// File: rtl/or_unit.sv
// or_unit -- bitwise-OR functional unit of the 8-bit ALU.
//
// Produces DATA1 | DATA2 combinationally for the ALU result mux, plus a
// registered copy of the result and its flags for writeback/debug.
//
// Ports:
//   CLK        rising-edge clock for the registered outputs
//   RESET      synchronous active-high reset; clears registered outputs
//   DATA1/2    operands (two's complement; only the flags care about sign)
//   IN_VALID   qualifies capture into the output registers
//   RESULT     combinational DATA1 | DATA2
//   ZERO, NEG  combinational flags of RESULT
//   RESULT_Q   registered RESULT, captured when IN_VALID
//   ZERO_Q     registered ZERO
//   NEG_Q      registered NEG
//   OUT_VALID  registered IN_VALID (high the cycle after a capture)

// Single-bit OR lane. A known 1 on either input gives 1 even when the
// other input is X, which is exactly the semantics of the | operator.
module or_lane (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module or_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             NEG,
  output logic [WIDTH-1:0] RESULT_Q,
  output logic             ZERO_Q,
  output logic             NEG_Q,
  output logic             OUT_VALID
);

  localparam int STAGES = 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
  } or_rsp_t;

  logic [WIDTH-1:0] res_w;
  or_rsp_t          rsp_c;
  or_rsp_t          rsp_q;
  logic [STAGES:0]  vld_pipe;

  // One lane per result bit; no carries, so lanes are fully independent.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    or_lane u_lane (
      .a (DATA1[i]),
      .b (DATA2[i]),
      .y (res_w[i])
    );
  end

  // Combinational path ignores CLK/RESET/IN_VALID entirely.
  always_comb begin
    rsp_c.result = res_w;
    rsp_c.zero   = (res_w == '0);
    rsp_c.neg    = res_w[WIDTH-1];
  end

  assign RESULT = rsp_c.result;
  assign ZERO   = rsp_c.zero;
  assign NEG    = rsp_c.neg;

  assign vld_pipe[0] = IN_VALID;

  // Reset dominates IN_VALID, discarding any capture on that edge.
  // Reset value reflects a zero result: ZERO_Q is 1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_q.result       <= '0;
      rsp_q.zero         <= 1'b1;
      rsp_q.neg          <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      if (vld_pipe[0]) rsp_q <= rsp_c;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  assign RESULT_Q  = rsp_q.result;
  assign ZERO_Q    = rsp_q.zero;
  assign NEG_Q     = rsp_q.neg;
  assign OUT_VALID = vld_pipe[STAGES];

endmodule

// File: tb/tb_or_unit.sv
// Self-checking bench for or_unit: directed vectors with hand-computed
// results, registered-path/reset behaviour, and a back-to-back random sweep.
module tb_or_unit;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [WIDTH-1:0] DATA1, DATA2;
  logic             IN_VALID;
  logic [WIDTH-1:0] RESULT, RESULT_Q;
  logic             ZERO, NEG, ZERO_Q, NEG_Q, OUT_VALID;

  int n_chk = 0;
  int n_err = 0;

  or_unit #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .IN_VALID  (IN_VALID),
    .RESULT    (RESULT),
    .ZERO      (ZERO),
    .NEG       (NEG),
    .RESULT_Q  (RESULT_Q),
    .ZERO_Q    (ZERO_Q),
    .NEG_Q     (NEG_Q),
    .OUT_VALID (OUT_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply operands, let the combinational path settle, check all three outputs.
  task automatic comb_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input logic z, input logic n);
    DATA1 = a;
    DATA2 = b;
    #1;
    chk({tag, ".result"}, 32'(RESULT), 32'(r));
    chk({tag, ".zero"},   32'(ZERO),   32'(z));
    chk({tag, ".neg"},    32'(NEG),    32'(n));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] a, b, exp_q;

    RESET    = 1'b1;
    IN_VALID = 1'b0;
    DATA1    = '0;
    DATA2    = '0;
    tick();
    chk("rst.result_q",  32'(RESULT_Q),  32'h00);
    chk("rst.zero_q",    32'(ZERO_Q),    32'd1);
    chk("rst.neg_q",     32'(NEG_Q),     32'd0);
    chk("rst.out_valid", 32'(OUT_VALID), 32'd0);
    RESET = 1'b0;
    tick();

    // Directed combinational vectors (negative operands as two's complement).
    comb_vec("v25_3", 8'd25, 8'd3,     8'h1B, 1'b0, 1'b0);
    comb_vec("v1_8",  8'd1,  8'd8,     8'h09, 1'b0, 1'b0);
    comb_vec("v2_m5", 8'd2,  8'hFB,    8'hFB, 1'b0, 1'b1);
    comb_vec("v6_m2", 8'd6,  8'hFE,    8'hFE, 1'b0, 1'b1);
    comb_vec("v0_0",  8'd0,  8'd0,     8'h00, 1'b1, 1'b0);
    comb_vec("vaa55", 8'hAA, 8'h55,    8'hFF, 1'b0, 1'b1);

    // Single valid pulse, then hold with IN_VALID low.
    DATA1 = 8'd25; DATA2 = 8'd3; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("cap.result_q",  32'(RESULT_Q),  32'd27);
    chk("cap.zero_q",    32'(ZERO_Q),    32'd0);
    chk("cap.neg_q",     32'(NEG_Q),     32'd0);
    chk("cap.out_valid", 32'(OUT_VALID), 32'd1);
    DATA1 = 8'h40; DATA2 = 8'h02;
    tick();
    chk("hold.result_q",  32'(RESULT_Q),  32'd27);
    chk("hold.out_valid", 32'(OUT_VALID), 32'd0);
    tick();
    chk("hold2.result_q", 32'(RESULT_Q),  32'd27);

    // Capture a negative result to exercise NEG_Q set.
    DATA1 = 8'h80; DATA2 = 8'h00; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("negcap.result_q", 32'(RESULT_Q), 32'h80);
    chk("negcap.neg_q",    32'(NEG_Q),    32'd1);

    // Reset wins over IN_VALID; combinational path stays live during reset.
    RESET = 1'b1; IN_VALID = 1'b1; DATA1 = 8'h80; DATA2 = 8'h01;
    #1;
    chk("rstv.result_comb", 32'(RESULT), 32'h81);
    chk("rstv.neg_comb",    32'(NEG),    32'd1);
    tick();
    chk("rstv.result_q",  32'(RESULT_Q),  32'h00);
    chk("rstv.zero_q",    32'(ZERO_Q),    32'd1);
    chk("rstv.neg_q",     32'(NEG_Q),     32'd0);
    chk("rstv.out_valid", 32'(OUT_VALID), 32'd0);
    RESET = 1'b0; IN_VALID = 1'b0;
    tick();

    // Back-to-back random sweep.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'h00; end
      DATA1 = a; DATA2 = b; IN_VALID = 1'b1;
      exp_q = a | b;
      #1;
      chk("rnd.result", 32'(RESULT), 32'(exp_q));
      tick();
      chk("rnd.result_q",  32'(RESULT_Q),  32'(exp_q));
      chk("rnd.zero_q",    32'(ZERO_Q),    32'(exp_q == 8'h00));
      chk("rnd.neg_q",     32'(NEG_Q),     32'(exp_q[7]));
      chk("rnd.out_valid", 32'(OUT_VALID), 32'd1);
    end
    IN_VALID = 1'b0;
    tick();
    chk("end.out_valid", 32'(OUT_VALID), 32'd0);
    chk("end.result_q",  32'(RESULT_Q),  32'(exp_q));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/or_unit.md
# or_unit

Bitwise-OR functional unit of the 8-bit ALU in the single-cycle processor. Produces the combinational OR of two signed operands for same-cycle use by the ALU result mux. Also provides a registered copy of the result and status flags for writeback/debug observation. Data are treated as raw bit vectors; signedness only affects flag interpretation.

## Interface
- WIDTH, 8, operand and result width in bits (processor uses 8).
- CLK  input  1  rising-edge clock for the registered outputs.
- RESET  input  1  synchronous, active-high reset; clears all registered outputs.
- DATA1  input  WIDTH  operand 1 (signed, two's complement).
- DATA2  input  WIDTH  operand 2 (signed, two's complement).
- IN_VALID  input  1  operands valid this cycle; qualifies capture into output registers.
- RESULT  output  WIDTH  combinational DATA1 | DATA2 (signed).
- ZERO  output  1  combinational; 1 when RESULT == 0.
- NEG  output  1  combinational; RESULT[WIDTH-1].
- RESULT_Q  output  WIDTH  registered RESULT, captured when IN_VALID.
- ZERO_Q  output  1  registered ZERO, captured with RESULT_Q.
- NEG_Q  output  1  registered NEG, captured with RESULT_Q.
- OUT_VALID  output  1  registered IN_VALID; 1 for exactly the cycle after a valid capture.

## Operation
- RESULT[i] = DATA1[i] OR DATA2[i] for every bit i; no carry, no overflow, no sign extension. Width of result equals operand width.
- ZERO = (RESULT == 0); NEG = MSB of RESULT.
- Combinational path has no dependence on CLK, RESET or IN_VALID; RESULT follows operands at all times, including while RESET is high.
- On rising CLK edge:
  - RESET = 1: RESULT_Q = 0, ZERO_Q = 1, NEG_Q = 0, OUT_VALID = 0 (reset wins over IN_VALID).
  - else IN_VALID = 1: RESULT_Q <= RESULT, ZERO_Q <= ZERO, NEG_Q <= NEG, OUT_VALID <= 1.
  - else: RESULT_Q, ZERO_Q, NEG_Q hold; OUT_VALID <= 0.
- No X propagation beyond inputs: bits with known inputs where either input is 1 must produce 1.

## Timing
- RESULT/ZERO/NEG: zero-cycle latency, pure combinational; must settle within the same cycle for the ALU mux.
- RESULT_Q/flags: one-cycle latency from a cycle with IN_VALID = 1.
- OUT_VALID: high for one cycle per accepted input; back-to-back IN_VALID gives continuous OUT_VALID with a new result every cycle.
- Reset values after the first RESET edge: RESULT_Q = 0x00, ZERO_Q = 1, NEG_Q = 0, OUT_VALID = 0. Reset asserted mid-stream discards the in-flight capture on that edge.
- No handshake back-pressure; every valid input is accepted.

## Test plan
- DATA1 = 25, DATA2 = 3 -> RESULT = 27 (00011011), ZERO = 0, NEG = 0, same cycle.
- DATA1 = 1, DATA2 = 8 -> RESULT = 9 (00001001); DATA1 = 2, DATA2 = -5 -> RESULT = -5 (11111011), NEG = 1.
- DATA1 = 6, DATA2 = -2 -> RESULT = -2 (11111110), NEG = 1; DATA1 = 0, DATA2 = 0 -> RESULT = 0, ZERO = 1.
- IN_VALID pulsed with 25|3, next edge -> RESULT_Q = 27, OUT_VALID = 1 for one cycle; later with IN_VALID = 0 and new operands -> RESULT_Q holds 27, OUT_VALID = 0.
- RESET = 1 with IN_VALID = 1 and operands 0x80|0x01 -> after edge RESULT_Q = 0, ZERO_Q = 1, NEG_Q = 0, OUT_VALID = 0, while RESULT = 0x81 combinationally.
- Random sweep, 1000 valid back-to-back operand pairs -> RESULT == DATA1|DATA2 each cycle and RESULT_Q equals previous cycle's expected value.
